// File: rtl/dnn_result_unit.sv
// Result stage: captures the class-score vector on core_done, runs a one-class-per-cycle
// signed argmax scan, and provides a registered bounds-checked readout of the captured bank.
module dnn_result_unit #(
    parameter int DATA_WIDTH  = 14,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                core_done,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0]   core_out,
    output logic                                busy,
    output logic                                result_valid,
    output logic [IDX_WIDTH-1:0]                result_class,
    output logic signed [DATA_WIDTH-1:0]        result_score,
    output logic                                overrun,
    input  logic [IDX_WIDTH-1:0]                rd_idx,
    output logic signed [DATA_WIDTH-1:0]        rd_data,
    output logic                                rd_err
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX    = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [IDX_WIDTH-1:0] FIRST_CNT   = IDX_WIDTH'((NUM_CLASSES > 1) ? 1 : 0);
    localparam logic [IDX_WIDTH:0]   CLASS_COUNT = (IDX_WIDTH + 1)'(NUM_CLASSES);

    state_t                      state, state_next;
    logic signed [DATA_WIDTH-1:0] bank [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0] best_score, cand_score, scan_score, class0;
    logic [IDX_WIDTH-1:0]        best_idx, cand_idx, cnt, rd_sel;
    logic                        rd_oob, scan_last;

    assign class0    = core_out[DATA_WIDTH-1:0];
    assign scan_last = (state == SCAN) && (cnt == LAST_IDX);

    // Strictly-greater replacement keeps the lowest index on ties.
    always_comb begin
        scan_score = bank[cnt];
        cand_score = best_score;
        cand_idx   = best_idx;
        if (scan_score > best_score) begin
            cand_score = scan_score;
            cand_idx   = cnt;
        end
    end

    always_comb begin
        rd_oob = ({1'b0, rd_idx} >= CLASS_COUNT);
        rd_sel = rd_oob ? '0 : rd_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else if (core_done) begin
            state_next = (NUM_CLASSES == 1) ? DONE : SCAN;
        end else if (scan_last) begin
            state_next = DONE;
        end
    end

    always_comb begin
        busy         = (state == SCAN);
        result_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank         <= '{default: '0};
            best_score   <= '0;
            best_idx     <= '0;
            cnt          <= '0;
            result_class <= '0;
            result_score <= '0;
            overrun      <= 1'b0;
            rd_data      <= '0;
            rd_err       <= 1'b0;
        end else begin
            // Readout samples the bank as it stood before this edge's capture.
            rd_data <= bank[rd_sel];
            rd_err  <= rd_oob;
            if (clear) begin
                overrun      <= 1'b0;
                result_class <= '0;
                result_score <= '0;
            end else if (core_done) begin
                for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
                    bank[k] <= core_out[k*DATA_WIDTH +: DATA_WIDTH];
                end
                best_score <= class0;
                best_idx   <= '0;
                cnt        <= FIRST_CNT;
                if (state == SCAN) begin
                    overrun <= 1'b1;
                end
                if (NUM_CLASSES == 1) begin
                    result_class <= '0;
                    result_score <= class0;
                end
            end else if (state == SCAN) begin
                best_score <= cand_score;
                best_idx   <= cand_idx;
                if (scan_last) begin
                    result_class <= cand_idx;
                    result_score <= cand_score;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dnn_result_unit.sv
// Directed/randomized bench for dnn_result_unit against an array-based argmax reference model.
module tb_dnn_result_unit;

    localparam int DW = 14;
    localparam int NC = 10;
    localparam int IW = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 clear = 1'b0;
    logic                 core_done = 1'b0;
    logic [NC*DW-1:0]     core_out = '0;
    logic [IW-1:0]        rd_idx = '0;
    logic                 busy, result_valid, overrun, rd_err;
    logic [IW-1:0]        result_class;
    logic signed [DW-1:0] result_score, rd_data;

    dnn_result_unit #(.DATA_WIDTH(DW), .NUM_CLASSES(NC), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .core_done(core_done), .core_out(core_out),
        .busy(busy), .result_valid(result_valid), .result_class(result_class),
        .result_score(result_score), .overrun(overrun), .rd_idx(rd_idx),
        .rd_data(rd_data), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic signed [DW-1:0] sc [NC];
    logic signed [DW-1:0] bank_m [NC];
    logic signed [DW-1:0] saved;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_argmax();
        int b = 0;
        for (int k = 1; k < NC; k++) if (bank_m[k] > bank_m[b]) b = k;
        return b;
    endfunction

    task automatic fill_random(input int lo, input int hi);
        for (int k = 0; k < NC; k++) sc[k] = DW'($urandom_range(hi - lo) + lo);
    endtask

    task automatic pulse_capture();
        for (int k = 0; k < NC; k++) core_out[k*DW +: DW] = sc[k];
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        for (int k = 0; k < NC; k++) bank_m[k] = sc[k];
    endtask

    // Called right after the capture edge; expects DONE exactly NC-1 edges later.
    task automatic finish_scan(input string tag);
        int w;
        check({tag, "_busy0"}, busy, 1);
        check({tag, "_valid0"}, result_valid, 0);
        for (int i = 1; i < NC - 1; i++) begin
            step();
            check({tag, "_busy"}, busy, 1);
        end
        step();
        w = model_argmax();
        check({tag, "_valid"}, result_valid, 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_class"}, result_class, w);
        check({tag, "_score"}, result_score, bank_m[w]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_valid"}, result_valid, 0);
        check({tag, "_class"}, result_class, 0);
        check({tag, "_score"}, result_score, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_rd_err"}, rd_err, 0);
    endtask

    initial begin
        for (int k = 0; k < NC; k++) bank_m[k] = '0;
        #12;
        check_all_zero("reset");
        rst = 1'b1;
        step();

        sc = '{-5, 3, 100, 7, -8192, 0, 99, 12, 1, 2};
        pulse_capture();
        finish_scan("distinct");
        check("distinct_class_const", result_class, 2);
        check("distinct_score_const", result_score, 100);

        for (int k = 0; k < NC; k++) sc[k] = -3;
        sc[4] = -1;
        sc[7] = -1;
        pulse_capture();
        finish_scan("tie");
        check("tie_class_const", result_class, 4);

        for (int k = 0; k < NC; k++) sc[k] = -8192;
        pulse_capture();
        finish_scan("allmin");
        check("allmin_class_const", result_class, 0);

        for (int r = 0; r < 12; r++) begin
            if (r % 2 == 0) fill_random(-8192, 8191);
            else fill_random(-2, 1);
            pulse_capture();
            finish_scan("random");
        end

        for (int i = 0; i < 16; i++) begin
            rd_idx = IW'(i);
            step();
            check("rd_err", rd_err, (i >= NC) ? 1 : 0);
            check("rd_data", rd_data, (i < NC) ? bank_m[i] : bank_m[0]);
        end

        rd_idx = 4'd2;
        saved = bank_m[2];
        fill_random(-8192, 8191);
        pulse_capture();
        check("rd_old_bank", rd_data, saved);
        step();
        check("rd_new_bank", rd_data, bank_m[2]);
        for (int i = 0; i < NC - 2; i++) step();
        check("rd_scan_valid", result_valid, 1);
        check("rd_scan_class", result_class, model_argmax());

        fill_random(-8192, 8191);
        pulse_capture();
        for (int i = 0; i < 4; i++) step();
        check("ovr_pre", overrun, 0);
        fill_random(-8192, 499);
        sc[9] = 500;
        pulse_capture();
        check("ovr_set", overrun, 1);
        finish_scan("overrun");
        check("ovr_class9", result_class, 9);
        check("ovr_score500", result_score, 500);
        step();
        step();
        check("ovr_sticky", overrun, 1);
        fill_random(-8192, 8191);
        pulse_capture();
        finish_scan("ovr_again");
        check("ovr_sticky_done", overrun, 1);

        rd_idx = 4'd3;
        saved = bank_m[3];
        fill_random(-8192, 8191);
        for (int k = 0; k < NC; k++) core_out[k*DW +: DW] = sc[k];
        clear = 1'b1;
        core_done = 1'b1;
        step();
        clear = 1'b0;
        core_done = 1'b0;
        check("clr_valid", result_valid, 0);
        check("clr_busy", busy, 0);
        check("clr_class", result_class, 0);
        check("clr_score", result_score, 0);
        check("clr_overrun", overrun, 0);
        step();
        check("clr_bank_kept", rd_data, saved);
        step();
        check("clr_idle_valid", result_valid, 0);
        check("clr_idle_busy", busy, 0);

        rd_idx = 4'd0;
        fill_random(-8192, 8191);
        pulse_capture();
        for (int i = 0; i < 4; i++) step();
        check("arst_busy_pre", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        for (int k = 0; k < NC; k++) bank_m[k] = '0;
        check_all_zero("arst");
        #2;
        rst = 1'b1;
        step();
        check("arst_idle_busy", busy, 0);
        check("arst_idle_valid", result_valid, 0);
        check("arst_bank_zero", rd_data, 0);
        fill_random(-8192, 8191);
        pulse_capture();
        finish_scan("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dnn_result_unit.md
# dnn_result_unit

Parametrised result stage placed between the fixed-point inference core and the host/readout logic. It captures the full class-score vector when the core signals completion, then runs a sequential signed argmax scan over the captured scores (one class per cycle) and reports the winning class and score. It also provides a registered, bounds-checked indexed readout of any captured score. It replaces the earlier fixed 10-way combinational output selector.

## Interface
- DATA_WIDTH, 14, signed score width.
- NUM_CLASSES, 10, number of class scores; must be >= 1.
- IDX_WIDTH, 4, index width; must satisfy 2**IDX_WIDTH >= NUM_CLASSES.

- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear; returns the block to IDLE.
- core_done  in  1  single-cycle completion pulse from the inference core.
- core_out  in  NUM_CLASSES*DATA_WIDTH  signed scores, packed; class k = bits [k*DATA_WIDTH +: DATA_WIDTH].
- busy  out  1  high while in SCAN.
- result_valid  out  1  high in DONE; argmax outputs are stable.
- result_class  out  IDX_WIDTH  winning class index.
- result_score  out  DATA_WIDTH  winning class score, signed.
- overrun  out  1  sticky; a core_done arrived during SCAN.
- rd_idx  in  IDX_WIDTH  readout index.
- rd_data  out  DATA_WIDTH  captured score at rd_idx, registered.
- rd_err  out  1  registered; rd_idx >= NUM_CLASSES.

## Operation
- Reset (rst low): state IDLE. Capture bank, busy, result_valid, result_class, result_score, overrun, rd_data, and rd_err are all 0.
- States: IDLE, SCAN, DONE.
- Capture: a core_done sampled high in any state except under clear has the following effect:
  - All NUM_CLASSES scores are loaded into the capture bank.
  - best_score is set to class 0 and best_idx to 0, and the scan counter is set to 1.
  - The next state is SCAN, or DONE directly if NUM_CLASSES == 1.
  - result_valid drops.
- SCAN: each cycle compares bank[cnt] with best_score as a signed comparison.
  - A strictly greater score replaces best. Ties keep the lower index.
  - cnt increments each cycle.
  - On the cycle cnt == NUM_CLASSES-1, the final compare is applied and the next state is DONE.
- DONE: result_class and result_score are loaded from best, and result_valid is held high. The block remains in DONE until the next core_done or clear.
- core_done during SCAN: the bank is recaptured and the scan restarts from class 0, and overrun is set. overrun stays set until clear or reset.
- clear: has priority over core_done in the same cycle.
  - The next state is IDLE, and result_valid, busy, and overrun go to 0.
  - result_class and result_score go to 0.
  - The capture bank is retained.
- Readout: at each edge, rd_data is loaded from bank[rd_idx] and rd_err is set to (rd_idx >= NUM_CLASSES).
  - When rd_idx is out of range, rd_data is loaded from bank[0].
  - Readout is independent of state and always reflects the current bank contents.
- Arithmetic: all comparisons are signed DATA_WIDTH. There is no saturation or extension.

## Timing
- Capture edge E0 is the edge at which core_done is sampled. The bank is valid after E0.
- SCAN occupies edges E1 through E(NUM_CLASSES-1). result_valid rises after edge E(NUM_CLASSES-1), which is 9 cycles after E0 at default parameters. With NUM_CLASSES == 1, result_valid rises after E0.
- busy is high after E0 and through the final SCAN edge. busy and result_valid are never both high.
- Readout latency is 1 cycle from rd_idx to rd_data/rd_err.
- A readout issued in the same cycle as a capture sees the old bank. It sees the new bank from the next cycle.
- Asynchronous assertion of rst mid-SCAN forces all outputs to 0 immediately. Operation resumes in IDLE after release.

## Test plan
- Distinct scores: core_out = {-5, 3, 100, 7, -8192, 0, 99, 12, 1, 2} for classes 0..9, with a core_done pulse. Required: busy for 9 cycles, then result_valid=1, result_class=2, result_score=100.
- Tie and negatives: all scores = -3 except class 4 = -1 and class 7 = -1. Required: result_class=4, result_score=-1. With all scores equal to -8192, required: result_class=0.
- Readout: after capture, step rd_idx through 0..15. Required: rd_data equals the class score one cycle later for indices 0..9. For indices 10..15, required: rd_err=1 and rd_data = class 0 score.
- Overrun: issue a second core_done 4 cycles into SCAN with class 9 = 500 as the maximum. Required: overrun=1, the scan restarts, result_class=9 appears 9 cycles after the second pulse, and overrun clears only on clear.
- Clear priority: assert clear and core_done in the same cycle while in DONE. Required: state IDLE, result_valid=0, result_class=0, overrun=0, and bank unchanged as seen on rd_data.
- Async reset: drop rst during SCAN cycle 5. Required: all outputs are 0 immediately. After release, a fresh core_done completes normally with 9-cycle latency.
